// File: rtl/tmds_pkg.sv
// Shared TMDS constants and the stage-1 transition-minimising helper.
// Used by the per-channel encoder and its top-level wrapper.
package tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'h354;
    localparam logic [9:0] TOK_C01 = 10'h0AB;
    localparam logic [9:0] TOK_C10 = 10'h154;
    localparam logic [9:0] TOK_C11 = 10'h2AB;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

    // q_m[8] = 1 marks the XOR chain, 0 the XNOR chain.
    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [3:0] n1;
        logic       useXnor;
        logic [8:0] q;
        n1      = popcount8(d);
        useXnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
        q       = '0;
        q[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = useXnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~useXnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrlToken(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b01:   t = TOK_C01;
            2'b10:   t = TOK_C10;
            2'b11:   t = TOK_C11;
            default: t = TOK_C00;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: stage 1 registers q_m and its ones count, stage 2 picks
// the DC-balancing symbol and keeps the channel's own running disparity.
module tmds_channel_enc
    import tmds_pkg::*;
#(
    parameter int kDispW = 5
) (
    input  logic                     PixelClk,
    input  logic                     pRst_n,
    input  logic [7:0]               pData,
    input  logic                     pDe,
    input  logic [1:0]               pCtl,
    output logic [9:0]               pSym,
    output logic signed [kDispW-1:0] pDisp
);

    localparam logic signed [kDispW-1:0] kEight = kDispW'(8);
    localparam logic signed [kDispW-1:0] kTwo   = kDispW'(2);
    localparam logic signed [kDispW-1:0] kZero  = '0;

    logic [8:0]               qmQ;
    logic [3:0]               n1Q;
    logic                     deQ;
    logic [1:0]               ctlQ;
    logic [9:0]               symNext;
    logic signed [kDispW-1:0] cntNext;
    logic signed [kDispW-1:0] bal;
    logic                     cntNeg;
    logic                     balNeg;

    always_ff @(posedge PixelClk) begin
        if (!pRst_n) begin
            qmQ   <= '0;
            n1Q   <= '0;
            deQ   <= 1'b0;
            ctlQ  <= 2'b00;
            pSym  <= TOK_C00;
            pDisp <= kZero;
        end else begin
            qmQ   <= tmds_qm(pData);
            n1Q   <= popcount8(tmds_qm(pData) >> 0 & 9'h0FF);
            deQ   <= pDe;
            ctlQ  <= pCtl;
            pSym  <= symNext;
            pDisp <= cntNext;
        end
    end

    // bal = n1 - n0 = 2*n1 - 8; the sign bits settle the "same side" test
    // because both operands are known non-zero in that branch.
    always_comb begin
        symNext = TOK_C00;
        cntNext = kZero;
        bal     = $signed(kDispW'({n1Q, 1'b0})) - kEight;
        cntNeg  = pDisp[kDispW-1];
        balNeg  = bal[kDispW-1];
        if (deQ) begin
            if ((pDisp == kZero) || (bal == kZero)) begin
                symNext = {~qmQ[8], qmQ[8], qmQ[8] ? qmQ[7:0] : ~qmQ[7:0]};
                cntNext = qmQ[8] ? (pDisp + bal) : (pDisp - bal);
            end else if (cntNeg == balNeg) begin
                symNext = {1'b1, qmQ[8], ~qmQ[7:0]};
                cntNext = pDisp + (qmQ[8] ? kTwo : kZero) - bal;
            end else begin
                symNext = {1'b0, qmQ[8], qmQ[7:0]};
                cntNext = pDisp - (qmQ[8] ? kZero : kTwo) + bal;
            end
        end else begin
            symNext = ctrlToken(ctlQ);
        end
    end

endmodule

// File: rtl/tmds_encoder_model.sv
// Behavioural N-channel TMDS encoder at pixel rate (no serialiser); channel 0
// carries HSync/VSync during control periods.
module tmds_encoder_model
    import tmds_pkg::*;
#(
    parameter int kChannels = 3,
    parameter int kDispW    = 5
) (
    input  logic                          PixelClk,
    input  logic                          pRst_n,
    input  logic [8*kChannels-1:0]        vid_pData,
    input  logic                          vid_pHSync,
    input  logic                          vid_pVSync,
    input  logic                          vid_pVDE,
    output logic [10*kChannels-1:0]       tmds_pSym,
    output logic                          tmds_pVld,
    output logic [kDispW*kChannels-1:0]   dbg_pDisp
);

    // tmds_pVld is a valid-only qualifier with no ready: symbols stream every
    // cycle, and it goes high once the two-stage pipeline holds post-reset input.
    logic [1:0] vldPipe;

    always_ff @(posedge PixelClk) begin
        if (!pRst_n) begin
            vldPipe <= 2'b00;
        end else begin
            vldPipe <= {vldPipe[0], 1'b1};
        end
    end

    assign tmds_pVld = vldPipe[1];

    for (genvar k = 0; k < kChannels; k++) begin : gCh
        logic [1:0]               chCtl;
        logic signed [kDispW-1:0] chDisp;

        assign chCtl = (k == 0) ? {vid_pVSync, vid_pHSync} : 2'b00;

        tmds_channel_enc #(.kDispW(kDispW)) uEnc (
            .PixelClk (PixelClk),
            .pRst_n   (pRst_n),
            .pData    (vid_pData[8*k +: 8]),
            .pDe      (vid_pVDE),
            .pCtl     (chCtl),
            .pSym     (tmds_pSym[10*k +: 10]),
            .pDisp    (chDisp)
        );

        assign dbg_pDisp[kDispW*k +: kDispW] = chDisp;
    end

endmodule
